// File: rtl/fpmul_pkg.sv
// Shared types and constant helpers for the pipelined floating-point multiplier.
package fpmul_pkg;

    typedef struct packed {
        logic exception;
        logic overflow;
        logic underflow;
        logic inexact;
    } fpmul_flags_t;

    // Operand classification carried down the pipe; exc means the result is a special/exception pattern.
    typedef struct packed {
        logic exc;
        logic inf;
        logic zero;
    } fpmul_cls_t;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Magnitude of infinity {all-ones exponent, zero mantissa}; callers truncate to their width.
    function automatic logic [127:0] inf_mag(input int exp_w, input int man_w);
        logic [127:0] one;
        one = 128'd1;
        return ((one << exp_w) - one) << man_w;
    endfunction

    function automatic logic [127:0] qnan_mag(input int exp_w, input int man_w);
        logic [127:0] one;
        one = 128'd1;
        return inf_mag(exp_w, man_w) | (one << (man_w - 1));
    endfunction

endpackage

// File: rtl/fpmul_round.sv
// Normalise a (2*MAN_W+2)-bit significand product and round to nearest even.
module fpmul_round #(
    parameter int MAN_W = 23
) (
    input  logic [2*MAN_W+1:0] prod,
    output logic [MAN_W-1:0]   man,
    output logic               norm_up,
    output logic               carry,
    output logic               inexact
);

    localparam int PW = 2 * MAN_W + 2;

    logic [PW-2:0]  norm;
    logic [MAN_W-1:0] man_raw;
    logic           guard;
    logic           sticky;
    logic           inc;
    logic [MAN_W:0] sum;

    // The hidden bit is dropped here; only the bits below it are kept.
    assign norm_up = prod[PW-1];
    assign norm    = norm_up ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    assign man_raw = norm[PW-2 -: MAN_W];
    assign guard   = norm[MAN_W];
    assign sticky  = |norm[MAN_W-1:0];
    assign inc     = guard & (sticky | man_raw[0]);
    assign sum     = {1'b0, man_raw} + {{MAN_W{1'b0}}, inc};
    assign carry   = sum[MAN_W];
    assign man     = sum[MAN_W-1:0];
    assign inexact = guard | sticky;

endmodule

// File: rtl/fp_mul_pipe.sv
// Pipelined FP multiplier: operand capture, unpack/multiply, normalise/round, pack/flags.
// Define FPMUL_IEEE_SPECIAL_EN for IEEE NaN/Inf handling; otherwise exp all-ones inputs give 0 with exception.
module fp_mul_pipe
    import fpmul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a_operand,
    input  logic [EXP_W+MAN_W:0]     b_operand,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     exception,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     inexact
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int EM_W = EXP_W + MAN_W;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int EW2  = EXP_W + 2;
    localparam logic signed [EW2-1:0] BIAS_S   = EW2'(bias(EXP_W));
    localparam logic signed [EW2-1:0] EXP_OVF  = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] EXP_ZERO = '0;
    localparam logic [EM_W-1:0]       INF_M    = EM_W'(inf_mag(EXP_W, MAN_W));
`ifdef FPMUL_IEEE_SPECIAL_EN
    localparam logic [W-1:0]          QNAN     = W'(qnan_mag(EXP_W, MAN_W));
`endif

    logic advance;
    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    logic             c_valid;
    logic [W-1:0]     c_a, c_b;
    logic [TAG_W-1:0] c_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_valid <= 1'b0;
            c_a     <= '0;
            c_b     <= '0;
            c_tag   <= '0;
        end else if (advance) begin
            c_valid <= in_valid;
            if (in_valid) begin
                c_a   <= a_operand;
                c_b   <= b_operand;
                c_tag <= in_tag;
            end
        end
    end

    logic [EXP_W-1:0]     a_exp, b_exp;
    logic [MAN_W-1:0]     a_man, b_man;
    logic                 a_zero, b_zero, a_sp, b_sp;
    logic [PW-1:0]        a_sig, b_sig, prod_d;
    logic signed [EW2-1:0] exp_sum_d;
    fpmul_cls_t           cls_d;

    assign a_exp  = c_a[W-2 -: EXP_W];
    assign b_exp  = c_b[W-2 -: EXP_W];
    assign a_man  = c_a[MAN_W-1:0];
    assign b_man  = c_b[MAN_W-1:0];
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_sp   = &a_exp;
    assign b_sp   = &b_exp;
    assign a_sig  = {{(MAN_W+1){1'b0}}, !a_zero, a_man};
    assign b_sig  = {{(MAN_W+1){1'b0}}, !b_zero, b_man};
    assign prod_d = a_sig * b_sig;
    assign exp_sum_d = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS_S;

`ifdef FPMUL_IEEE_SPECIAL_EN
    logic a_nan, b_nan, a_inf, b_inf;
    assign a_nan = a_sp & (a_man != '0);
    assign b_nan = b_sp & (b_man != '0);
    assign a_inf = a_sp & (a_man == '0);
    assign b_inf = b_sp & (b_man == '0);
    assign cls_d.exc  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    assign cls_d.inf  = !cls_d.exc & (a_inf | b_inf);
    assign cls_d.zero = a_zero | b_zero;
`else
    assign cls_d.exc  = a_sp | b_sp;
    assign cls_d.inf  = 1'b0;
    assign cls_d.zero = a_zero | b_zero;
`endif

    logic                  s1_valid, s1_sign;
    logic [PW-1:0]         s1_prod;
    logic signed [EW2-1:0] s1_exp;
    fpmul_cls_t            s1_cls;
    logic [TAG_W-1:0]      s1_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_prod  <= '0;
            s1_exp   <= '0;
            s1_cls   <= '0;
            s1_tag   <= '0;
        end else if (advance) begin
            s1_valid <= c_valid;
            s1_sign  <= c_a[W-1] ^ c_b[W-1];
            s1_prod  <= prod_d;
            s1_exp   <= exp_sum_d;
            s1_cls   <= cls_d;
            s1_tag   <= c_tag;
        end
    end

    logic [MAN_W-1:0]      rnd_man;
    logic                  rnd_norm_up, rnd_carry, rnd_inexact;
    logic [1:0]            exp_adj;
    logic signed [EW2-1:0] s2_exp_d;

    fpmul_round #(.MAN_W(MAN_W)) u_round (
        .prod    (s1_prod),
        .man     (rnd_man),
        .norm_up (rnd_norm_up),
        .carry   (rnd_carry),
        .inexact (rnd_inexact)
    );

    assign exp_adj  = {1'b0, rnd_norm_up} + {1'b0, rnd_carry};
    assign s2_exp_d = s1_exp + $signed({{EXP_W{1'b0}}, exp_adj});

    logic                  s2_valid, s2_sign, s2_inexact;
    logic [MAN_W-1:0]      s2_man;
    logic signed [EW2-1:0] s2_exp;
    fpmul_cls_t            s2_cls;
    logic [TAG_W-1:0]      s2_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_sign    <= 1'b0;
            s2_inexact <= 1'b0;
            s2_man     <= '0;
            s2_exp     <= '0;
            s2_cls     <= '0;
            s2_tag     <= '0;
        end else if (advance) begin
            s2_valid   <= s1_valid;
            s2_sign    <= s1_sign;
            s2_inexact <= rnd_inexact;
            s2_man     <= rnd_man;
            s2_exp     <= s2_exp_d;
            s2_cls     <= s1_cls;
            s2_tag     <= s1_tag;
        end
    end

    logic [W-1:0] res_d;
    fpmul_flags_t flg_d, flg_q;

    always_comb begin
        res_d = '0;
        flg_d = '0;
        if (s2_cls.exc) begin
`ifdef FPMUL_IEEE_SPECIAL_EN
            res_d = QNAN;
`else
            res_d = '0;
`endif
            flg_d.exception = 1'b1;
        end else if (s2_cls.inf) begin
            res_d = {s2_sign, INF_M};
        end else if (s2_cls.zero) begin
            res_d = {s2_sign, {EM_W{1'b0}}};
        end else if (s2_exp >= EXP_OVF) begin
            res_d = {s2_sign, INF_M};
            flg_d.overflow = 1'b1;
            flg_d.inexact  = 1'b1;
        end else if (s2_exp <= EXP_ZERO) begin
            res_d = {s2_sign, {EM_W{1'b0}}};
            flg_d.underflow = 1'b1;
            flg_d.inexact   = 1'b1;
        end else begin
            res_d = {s2_sign, s2_exp[EXP_W-1:0], s2_man};
            flg_d.inexact = s2_inexact;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            out_tag   <= '0;
            flg_q     <= '0;
        end else if (advance) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                result  <= res_d;
                out_tag <= s2_tag;
                flg_q   <= flg_d;
            end
        end
    end

    assign exception = flg_q.exception;
    assign overflow  = flg_q.overflow;
    assign underflow = flg_q.underflow;
    assign inexact   = flg_q.inexact;

endmodule
